// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a framed byte stream (length, LE words,
// XOR checksum), writes words to consecutive addresses and holds the CPU while loading.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_Din,
    output logic              Cpu_Hold,
    output logic              Done,
    output logic              Error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t            state, state_next;
    logic [15:0]       len;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [7:0]        acc;
    logic [23:0]       word_buf;
    logic              accept;
    logic              start_ok;
    logic              oversize;
    logic              len_zero;
    logic              last_word;

    assign accept    = Byte_Valid && Byte_Ready;
    assign start_ok  = Start && (state inside {S_IDLE, S_DONE, S_ERROR});
    assign oversize  = {16'd0, Byte_In, len[7:0]} > MAX_WORDS;
    assign len_zero  = ({Byte_In, len[7:0]} == 16'd0);
    // Word counter is one bit wider than the address so N == MAX_WORDS compares without wrap.
    assign last_word = (byte_cnt == 2'd3) &&
                       (({{(31-ADDR_W){1'b0}}, word_cnt} + 32'd1) == {16'd0, len});

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (Start) state_next = S_LEN_LO;
            S_LEN_LO: if (accept) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (oversize)      state_next = S_ERROR;
                    else if (len_zero) state_next = S_CHECK;
                    else               state_next = S_DATA;
                end
            end
            S_DATA:  if (accept && last_word) state_next = S_CHECK;
            S_CHECK: if (accept) state_next = (Byte_In == acc) ? S_DONE : S_ERROR;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Byte_Ready = (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK});
        Cpu_Hold   = !(state inside {S_IDLE, S_DONE});
        Done       = (state == S_DONE);
        Error      = (state == S_ERROR);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            len      <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            acc      <= '0;
            word_buf <= '0;
            Mem_WE   <= 1'b0;
            Mem_Addr <= '0;
            Mem_Din  <= '0;
        end else begin
            Mem_WE <= 1'b0;
            if (start_ok) begin
                len      <= '0;
                byte_cnt <= '0;
                word_cnt <= '0;
                acc      <= '0;
                word_buf <= '0;
            end else if (accept) begin
                case (state)
                    S_LEN_LO: len[7:0]  <= Byte_In;
                    S_LEN_HI: len[15:8] <= Byte_In;
                    S_DATA: begin
                        acc      <= acc ^ Byte_In;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= Byte_In;
                            2'd1: word_buf[15:8]  <= Byte_In;
                            2'd2: word_buf[23:16] <= Byte_In;
                            default: begin
                                Mem_WE   <= 1'b1;
                                Mem_Addr <= word_cnt[ADDR_W-1:0];
                                Mem_Din  <= {Byte_In, word_buf};
                                word_cnt <= word_cnt + (ADDR_W+1)'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed/random bench for imem_loader: a frame-level model predicts writes and status.
module tb_imem_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              Clk = 1'b0;
    logic              Reset, Start, Byte_Valid;
    logic [7:0]        Byte_In;
    logic              Byte_Ready, Mem_WE, Cpu_Hold, Done, Error;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_Din;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [31:0]       words[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];
    int                obs_cyc[$];

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Byte_In(Byte_In),
        .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready), .Mem_WE(Mem_WE),
        .Mem_Addr(Mem_Addr), .Mem_Din(Mem_Din), .Cpu_Hold(Cpu_Hold),
        .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc = cyc + 1;

    always @(negedge Clk) begin
        if (Mem_WE === 1'b1) begin
            obs_addr.push_back(Mem_Addr);
            obs_data.push_back(Mem_Din);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    task automatic pulse_start();
        Byte_Valid = 1'b0;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Presents one byte after up to gap_max idle cycles; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int  gaps;
        bit  got;
        logic rdy;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (gaps) begin
            Byte_Valid = 1'b0;
            Byte_In = 8'($urandom);
            @(negedge Clk);
        end
        Byte_In = b;
        Byte_Valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            rdy = Byte_Ready;
            @(negedge Clk);
            if (rdy === 1'b1) got = 1'b1;
        end
        if (!got) chk("byte_accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic check_writes(input int n, input bit spacing);
        int m;
        chk("wr_count", 64'(obs_addr.size()), 64'(n));
        m = (obs_addr.size() < n) ? obs_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("wr[%0d]", i), {22'd0, obs_addr[i], obs_data[i]},
                {22'd0, ADDR_W'(i), words[i]});
            if (spacing && i > 0)
                chk($sformatf("wr_gap[%0d]", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd4);
        end
    endtask

    task automatic load(input int n, input bit bad, input int gap, input bit spacing);
        logic [15:0] nl;
        logic [7:0]  ck;
        logic [31:0] w;
        nl = 16'(n);
        clear_obs();
        pulse_start();
        chk("hold_after_start", 64'(Cpu_Hold), 64'd1);
        chk("status_cleared", 64'({Done, Error}), 64'd0);
        send_byte(nl[7:0], gap);
        send_byte(nl[15:8], gap);
        if (n > MAX_WORDS) begin
            Byte_Valid = 1'b0;
            chk("oversize_error", 64'({Done, Error}), 64'd1);
            chk("oversize_ready", 64'(Byte_Ready), 64'd0);
            repeat (3) @(negedge Clk);
            check_writes(0, 1'b0);
            return;
        end
        ck = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8], gap);
                ck = ck ^ w[8*b +: 8];
            end
        end
        send_byte(bad ? (ck ^ 8'h01) : ck, gap);
        Byte_Valid = 1'b0;
        chk("end_status", 64'({Done, Error}), bad ? 64'd1 : 64'd2);
        chk("end_hold", 64'(Cpu_Hold), 64'(bad));
        chk("end_ready", 64'(Byte_Ready), 64'd0);
        repeat (2) @(negedge Clk);
        check_writes(n, spacing);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Byte_Valid = 1'b0; Byte_In = 8'd0;
        repeat (3) @(negedge Clk);
        chk("reset_outs", 64'({Byte_Ready, Mem_WE, Mem_Addr, Mem_Din, Cpu_Hold, Done, Error}), 64'd0);
        Reset = 1'b0;

        clear_obs();
        Byte_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Byte_In = 8'($urandom);
            @(negedge Clk);
            chk("idle_ready", 64'({Byte_Ready, Cpu_Hold}), 64'd0);
        end
        Byte_Valid = 1'b0;
        check_writes(0, 1'b0);

        words = '{32'h00500013, 32'h00100093};
        load(2, 1'b0, 0, 1'b1);

        load(2, 1'b1, 0, 1'b1);

        load(2, 1'b0, 3, 1'b0);

        words.delete();
        for (int i = 0; i < 6; i++) words.push_back($urandom);
        load(6, 1'b0, 4, 1'b0);

        words.delete();
        load(0, 1'b0, 0, 1'b0);

        load(1025, 1'b0, 0, 1'b0);

        for (int i = 0; i < MAX_WORDS; i++) words.push_back($urandom);
        load(MAX_WORDS, 1'b0, 0, 1'b1);
        chk("last_addr", 64'(obs_addr[obs_addr.size()-1]), 64'(MAX_WORDS - 1));

        words.delete();
        words = '{32'hdeadbeef, 32'h12345678};
        clear_obs();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int b = 0; b < 5; b++) send_byte(b < 4 ? words[0][8*b +: 8] : words[1][7:0], 0);
        Byte_Valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midreset_outs", 64'({Byte_Ready, Cpu_Hold, Done, Error}), 64'd0);
        Byte_Valid = 1'b1;
        repeat (6) begin
            Byte_In = 8'($urandom);
            @(negedge Clk);
        end
        Byte_Valid = 1'b0;
        check_writes(1, 1'b0);
        words = '{32'h00500013, 32'h00100093};
        load(2, 1'b0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
